asa_pio_master: RTL and testbench

ASA_PIO_MASTER -- requirements
Module: asa_pio_master

---
 rtl/asa_pio_master.sv | 189 ++++++++++++++++++
 tb/tb_asa_pio_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asa_pio_master.sv
// Single-outstanding PIO bus master: accepts one host command, runs ISSUE/WAIT on the register bus, then drains.
// Optional WAIT/DRAIN timeout is enabled by defining ASA_PIO_MASTER_TIMEOUT_EN.
module asa_pio_master #(
    parameter int unsigned PIO_NBITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_div,
    input  logic                 host_req,
    input  logic                 host_wr,
    input  logic [PIO_NBITS-1:0] host_addr,
    input  logic [PIO_NBITS-1:0] host_wdata,
    output logic                 host_gnt,
    output logic                 host_done,
    output logic                 host_err,
    output logic [PIO_NBITS-1:0] host_rdata,
    output logic                 reg_bs,
    output logic                 reg_wr,
    output logic                 reg_rd,
    output logic [PIO_NBITS-1:0] reg_addr,
    output logic [PIO_NBITS-1:0] reg_din,
    input  logic                 pio_ack,
    input  logic                 pio_rvalid,
    input  logic [PIO_NBITS-1:0] pio_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic                   wr_q, wr_d;
    logic                   host_gnt_q, host_gnt_d;
    logic                   host_done_q, host_done_d;
    logic [PIO_NBITS-1:0]   host_rdata_q, host_rdata_d;
    logic                   reg_bs_q, reg_bs_d;
    logic                   reg_wr_q, reg_wr_d;
    logic                   reg_rd_q, reg_rd_d;
    logic [PIO_NBITS-1:0]   reg_addr_q, reg_addr_d;
    logic [PIO_NBITS-1:0]   reg_din_q, reg_din_d;
    logic                   wait_hit;
    logic                   bus_quiet;
    logic                   cnt_expired;
    logic                   host_err_d;

`ifdef ASA_PIO_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             host_err_q;

    // Counter value in WAIT/DRAIN cycle k is k-1, so this marks the TIMEOUT_CYCLES-th cycle.
    assign cnt_expired = (cnt_q >= CNT_LAST);
`else
    assign cnt_expired = 1'b0;
`endif

    assign wait_hit  = wr_q ? pio_ack : pio_rvalid;
    assign bus_quiet = ~pio_ack & ~pio_rvalid;

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        host_done_d  = 1'b0;
        host_err_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        reg_addr_d   = reg_addr_q;
        reg_din_d    = reg_din_q;
`ifdef ASA_PIO_MASTER_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (host_req && host_gnt_q) begin
                    state_d    = ISSUE;
                    wr_d       = host_wr;
                    reg_addr_d = host_addr;
                    reg_din_d  = host_wdata;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef ASA_PIO_MASTER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // Completion wins over a timeout landing on the same cycle.
                if (wait_hit) begin
                    state_d      = DRAIN;
                    host_done_d  = 1'b1;
                    host_rdata_d = wr_q ? '0 : pio_rdata;
`ifdef ASA_PIO_MASTER_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end else if (cnt_expired) begin
                    state_d      = DRAIN;
                    host_done_d  = 1'b1;
                    host_err_d   = 1'b1;
                    host_rdata_d = '1;
`ifdef ASA_PIO_MASTER_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end else begin
`ifdef ASA_PIO_MASTER_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            DRAIN: begin
                // Exit only on a slow-phase strobe so the responder's registered ack has settled.
                if (clk_div && (bus_quiet || cnt_expired)) begin
                    state_d = IDLE;
                end else begin
`ifdef ASA_PIO_MASTER_TIMEOUT_EN
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
        endcase

        host_gnt_d = (state_d == IDLE);
        reg_bs_d   = (state_d == ISSUE) || (state_d == WAIT);
        reg_wr_d   = (state_d == ISSUE) && wr_d;
        reg_rd_d   = (state_d == ISSUE) && !wr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            host_gnt_q   <= 1'b1;
            host_done_q  <= 1'b0;
            host_rdata_q <= '0;
            reg_bs_q     <= 1'b0;
            reg_wr_q     <= 1'b0;
            reg_rd_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_din_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            host_gnt_q   <= host_gnt_d;
            host_done_q  <= host_done_d;
            host_rdata_q <= host_rdata_d;
            reg_bs_q     <= reg_bs_d;
            reg_wr_q     <= reg_wr_d;
            reg_rd_q     <= reg_rd_d;
            reg_addr_q   <= reg_addr_d;
            reg_din_q    <= reg_din_d;
        end
    end

`ifdef ASA_PIO_MASTER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            host_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            host_err_q <= host_err_d;
        end
    end

    assign host_err = host_err_q;
`else
    // Without the timeout an error completion cannot occur.
    assign host_err = host_err_d;
`endif

    assign host_gnt   = host_gnt_q;
    assign host_done  = host_done_q;
    assign host_rdata = host_rdata_q;
    assign reg_bs     = reg_bs_q;
    assign reg_wr     = reg_wr_q;
    assign reg_rd     = reg_rd_q;
    assign reg_addr   = reg_addr_q;
    assign reg_din    = reg_din_q;

endmodule

// File: tb/tb_asa_pio_master.sv
// Randomized self-checking bench for asa_pio_master; expectations come from a per-transaction timing model.
module tb_asa_pio_master;

    localparam int unsigned NB = 8;
`ifdef ASA_PIO_MASTER_TIMEOUT_EN
    localparam int TO        = 8;
    localparam int DRAIN_LIM = 8;
`else
    localparam int TO        = 255;
    localparam int DRAIN_LIM = 1 << 30;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_div;
    logic          host_req;
    logic          host_wr;
    logic [NB-1:0] host_addr;
    logic [NB-1:0] host_wdata;
    logic          host_gnt;
    logic          host_done;
    logic          host_err;
    logic [NB-1:0] host_rdata;
    logic          reg_bs;
    logic          reg_wr;
    logic          reg_rd;
    logic [NB-1:0] reg_addr;
    logic [NB-1:0] reg_din;
    logic          pio_ack;
    logic          pio_rvalid;
    logic [NB-1:0] pio_rdata;

    int n_vec = 0;
    int n_err = 0;

    asa_pio_master #(
        .PIO_NBITS      (NB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .host_req   (host_req),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_done  (host_done),
        .host_err   (host_err),
        .host_rdata (host_rdata),
        .reg_bs     (reg_bs),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_addr   (reg_addr),
        .reg_din    (reg_din),
        .pio_ack    (pio_ack),
        .pio_rvalid (pio_rvalid),
        .pio_rdata  (pio_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous reset; outputs checked while reset is still held and after release.
    task automatic test_reset();
        rst        = 1'b1;
        host_req   = 1'b0;
        host_wr    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        clk_div    = 1'b1;
        pio_ack    = 1'b1;
        pio_rvalid = 1'b1;
        pio_rdata  = NB'($urandom);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({host_gnt, host_done, host_err, reg_bs, reg_wr, reg_rd, host_rdata, reg_addr, reg_din}
            !== {1'b1, 5'b0, {(3*NB){1'b0}}}) begin
            n_err++;
            $display("FAIL reset_state: got gnt=%b done=%b err=%b bs=%b wr=%b rd=%b rdata=%h addr=%h din=%h want gnt=1 rest 0",
                     host_gnt, host_done, host_err, reg_bs, reg_wr, reg_rd, host_rdata, reg_addr, reg_din);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({host_gnt, host_done, reg_bs} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_release: got gnt/done/bs=%b want 100 (responder strobes in IDLE ignored)",
                     {host_gnt, host_done, reg_bs});
        end
        pio_ack    = 1'b0;
        pio_rvalid = 1'b0;
    endtask

    // One full transaction. n_ack = WAIT cycle on which the responder first answers (0 = never).
    // Model: completion on that cycle if within TO (timeout build), else timeout on WAIT cycle TO;
    // DRAIN exits on the first clk_div cycle with both strobes low, or on/after DRAIN cycle DRAIN_LIM.
    task automatic do_txn(input bit wr, input logic [NB-1:0] addr, input logic [NB-1:0] wdata,
                          input int n_ack, input logic [NB-1:0] rd, input int linger, input bit hold_ack);
        int            done_k;
        bit            exp_err;
        logic [NB-1:0] exp_rdata;
        bit            resp;
        bit            ex;
        bit            lg;
`ifdef ASA_PIO_MASTER_TIMEOUT_EN
        if (n_ack >= 1 && n_ack <= TO) begin
            done_k  = n_ack;
            exp_err = 1'b0;
        end else begin
            done_k  = TO;
            exp_err = 1'b1;
        end
`else
        done_k  = n_ack;
        exp_err = 1'b0;
`endif
        exp_rdata = exp_err ? {NB{1'b1}} : (wr ? {NB{1'b0}} : rd);

        n_vec++;
        if (host_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL idle_gnt: got host_gnt=%b want 1", host_gnt);
        end
        host_req   = 1'b1;
        host_wr    = wr;
        host_addr  = addr;
        host_wdata = wdata;
        pio_ack    = 1'($urandom);
        pio_rvalid = 1'($urandom);
        pio_rdata  = NB'($urandom);
        clk_div    = 1'($urandom);
        @(negedge clk);

        n_vec++;
        if ({reg_bs, reg_wr, reg_rd, host_gnt, host_done, reg_addr, reg_din}
            !== {1'b1, wr, !wr, 1'b0, 1'b0, addr, wdata}) begin
            n_err++;
            $display("FAIL issue_out: got bs=%b wr=%b rd=%b gnt=%b done=%b addr=%h din=%h want 1 %b %b 0 0 %h %h",
                     reg_bs, reg_wr, reg_rd, host_gnt, host_done, reg_addr, reg_din, wr, !wr, addr, wdata);
        end
        host_req   = 1'b0;
        host_wr    = 1'($urandom);
        host_addr  = NB'($urandom);
        host_wdata = NB'($urandom);
        pio_ack    = 1'($urandom);
        pio_rvalid = 1'($urandom);
        clk_div    = 1'($urandom);
        @(negedge clk);

        for (int k = 1; k <= 400; k++) begin
            n_vec++;
            if ({reg_bs, reg_wr, reg_rd, host_gnt, host_done, reg_addr, reg_din}
                !== {5'b10000, addr, wdata}) begin
                n_err++;
                $display("FAIL wait_out k=%0d: got bs=%b wr=%b rd=%b gnt=%b done=%b addr=%h din=%h want 1 0 0 0 0 %h %h",
                         k, reg_bs, reg_wr, reg_rd, host_gnt, host_done, reg_addr, reg_din, addr, wdata);
            end
            resp = (n_ack != 0) && (k >= n_ack);
            if (wr) begin
                pio_ack    = resp;
                pio_rvalid = 1'($urandom);
                pio_rdata  = NB'($urandom);
            end else begin
                pio_rvalid = resp;
                pio_ack    = hold_ack ? 1'b1 : 1'($urandom);
                pio_rdata  = resp ? rd : NB'($urandom);
            end
            clk_div = 1'($urandom);
            @(negedge clk);
            if (k == done_k) break;
        end

        if (done_k == 0) begin
            // No completion expected: recover the bus with a reset.
            rst        = 1'b1;
            pio_ack    = 1'b0;
            pio_rvalid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            return;
        end

        n_vec++;
        if ({host_done, host_err, reg_bs, reg_wr, reg_rd, host_gnt, host_rdata}
            !== {1'b1, exp_err, 4'b0000, exp_rdata}) begin
            n_err++;
            $display("FAIL completion: got done=%b err=%b bs=%b wr=%b rd=%b gnt=%b rdata=%h want 1 %b 0 0 0 0 %h",
                     host_done, host_err, reg_bs, reg_wr, reg_rd, host_gnt, host_rdata, exp_err, exp_rdata);
        end

        for (int d = 1; d <= 600; d++) begin
            lg         = (d <= linger);
            pio_ack    = lg ? (wr ? 1'b1 : 1'($urandom)) : 1'b0;
            pio_rvalid = lg ? 1'($urandom) : 1'b0;
            pio_rdata  = NB'($urandom);
            clk_div    = 1'($urandom);
            ex = clk_div && ((!pio_ack && !pio_rvalid) || (d >= DRAIN_LIM));
            @(negedge clk);
            n_vec++;
            if ({host_gnt, host_done, reg_bs} !== {ex, 2'b00}) begin
                n_err++;
                $display("FAIL drain d=%0d: got gnt/done/bs=%b want %b", d, {host_gnt, host_done, reg_bs}, {ex, 2'b00});
            end
            if (ex) break;
        end
        pio_ack    = 1'b0;
        pio_rvalid = 1'b0;
    endtask

    // Reset while waiting on the responder must drop the bus with no completion pulse.
    task automatic test_reset_mid();
        host_req   = 1'b1;
        host_wr    = 1'b1;
        host_addr  = 8'h33;
        host_wdata = 8'hC3;
        @(negedge clk);
        host_req = 1'b0;
        pio_ack  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (reg_bs !== 1'b1) begin
            n_err++;
            $display("FAIL mid_wait_bs: got reg_bs=%b want 1", reg_bs);
        end
        rst     = 1'b1;
        pio_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({reg_bs, reg_wr, reg_rd, host_done, host_err, host_gnt, reg_addr, host_rdata}
            !== {6'b000001, {(2*NB){1'b0}}}) begin
            n_err++;
            $display("FAIL mid_reset: got bs=%b wr=%b rd=%b done=%b err=%b gnt=%b addr=%h rdata=%h want 0 0 0 0 0 1 00 00",
                     reg_bs, reg_wr, reg_rd, host_done, host_err, host_gnt, reg_addr, host_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({host_done, host_gnt, reg_bs} !== 3'b010) begin
                n_err++;
                $display("FAIL post_reset i=%0d: got done/gnt/bs=%b want 010", i, {host_done, host_gnt, reg_bs});
            end
        end
        pio_ack = 1'b0;
    endtask

    task automatic test_directed();
        do_txn(1'b1, 8'h10, 8'hA5, 3, 8'h00, 0, 1'b0);
        do_txn(1'b0, 8'h20, 8'h00, 2, 8'h5A, 0, 1'b1);
        do_txn(1'b1, 8'h44, 8'h12, TO, 8'h00, 0, 1'b0);
        do_txn(1'b0, 8'h45, 8'h00, TO + 3, 8'h77, 0, 1'b0);
        do_txn(1'b1, 8'h46, 8'h99, 1, 8'h00, 30, 1'b0);
    endtask

    task automatic test_no_ack();
        do_txn(1'b1, 8'h50, 8'h3C, 0, 8'h00, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_txn(1'b1, 8'h60, 8'h01, 1, 8'h00, 2, 1'b0);
        do_txn(1'b0, 8'h61, 8'h00, 1, 8'hE7, 2, 1'b0);
        do_txn(1'b1, 8'h62, 8'h02, 1, 8'h00, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom), NB'($urandom), NB'($urandom), $urandom_range(1, 12),
                   NB'($urandom), $urandom_range(0, 4), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_no_ack();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
